// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional perf counter in fetch_unit is enabled by FETCH_PERF_CNT_EN.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc4;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry FIFO holding fetched {instr, pc4} pairs for decode.
// Flush empties it in one edge; the head stays stable until popped.
module fetch_fifo2
  import fetch_unit_pkg::*;
(
  input  logic      clk,
  input  logic      arst_n,
  input  logic      i_flush,
  input  logic      i_wr_en,
  input  fq_entry_t i_wr_data,
  input  logic      i_rd_en,
  output fq_entry_t o_rd_data,
  output logic      o_not_empty,
  output logic [1:0] o_count
);

  fq_entry_t  r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_cnt;

  logic w_push;
  logic w_pop;

  assign w_pop  = i_rd_en && (r_cnt != 2'd0);
  assign w_push = i_wr_en && ((r_cnt != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_flush) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wr_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_rd_data   = r_mem[r_rptr];
  assign o_not_empty = (r_cnt != 2'd0);
  assign o_count     = r_cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, 1-cycle imem, 2-entry queue, redirects.
// `define FETCH_PERF_CNT_EN to add the fetch_count transfer counter.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            arst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            branch_en,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_target,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc4,
  output logic            instr_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_count
`endif
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;

  logic [XLEN-1:0] r_pc;
  logic            r_inflight;

  logic            w_redir;
  logic [XLEN-1:0] w_target;
  logic            w_wr;
  logic [1:0]      w_cnt;
  fq_entry_t       w_wr_data;
  fq_entry_t       w_head;

  assign w_redir  = branch_en || jump_en;
  assign w_target = word_align(branch_en ? branch_target
                                         : jump_target);

  always_comb begin
    w_next_state = r_state;
    imem_req     = 1'b0;
    unique case (r_state)
      S_BOOT: begin
        w_next_state = S_RUN;
      end
      S_RUN, S_DRAIN: begin
        imem_req = !w_redir &&
          (({1'b0, w_cnt} + {2'b00, r_inflight}) < 3'd2);
        if (w_redir) begin
          w_next_state = r_inflight ? S_DRAIN : S_RUN;
        end else begin
          w_next_state = S_RUN;
        end
      end
      default: begin
        w_next_state = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_inflight <= imem_req;
      if (w_redir) begin
        r_pc <= w_target;
      end else if (imem_req) begin
        r_pc <= r_pc + 32'd4;
      end
    end
  end

  // PC already advanced past the in-flight request, so it is that pc4
  assign w_wr = r_inflight && !w_redir && (r_state != S_DRAIN);
  assign w_wr_data = '{instr: imem_rdata, pc4: r_pc};

  fetch_fifo2 u_fifo (
    .clk         (clk),
    .arst_n      (arst_n),
    .i_flush     (w_redir),
    .i_wr_en     (w_wr),
    .i_wr_data   (w_wr_data),
    .i_rd_en     (instr_ready),
    .o_rd_data   (w_head),
    .o_not_empty (instr_valid),
    .o_count     (w_cnt)
  );

  assign imem_addr = r_pc;
  assign instr     = w_head.instr;
  assign instr_pc4 = w_head.pc4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_fetch_cnt <= 32'd0;
    end else if (instr_valid && instr_ready) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign fetch_count = r_fetch_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle imem model.
// Imem returns addr + 0x2000_0001 for every fetched word.
module tb_fetch_unit;

  logic        clk;
  logic        arst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc4;
  logic        instr_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int n_chk;
  int n_fail;
  int reqs;

  fetch_unit dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc4     (instr_pc4),
    .instr_valid   (instr_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h2000_0001;
  endfunction

  always @(posedge clk) begin
    imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the head, check it, let it transfer.
  task automatic take(input string tag, input logic [31:0] pc4);
    int n;
    n = 0;
    instr_ready = 1'b1;
    #1;
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_instr"}, instr, mem_word(pc4 - 32'd4));
    chk({tag, "_pc4"}, instr_pc4, pc4);
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    arst_n        = 1'b0;
    branch_en     = 1'b0;
    branch_target = 32'd0;
    jump_en       = 1'b0;
    jump_target   = 32'd0;
    instr_ready   = 1'b0;
    imem_rdata    = 32'd0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc4", instr_pc4, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);

    // first fetch latency
    instr_ready = 1'b1;
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    chk("boot_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    #1;
    chk("c1_req", {31'd0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr, 32'd0);
    @(negedge clk);
    #1;
    chk("c2_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    take("c3", 32'd4);
    take("s8", 32'd8);

    // reset mid-fetch, then stall decode
    arst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    @(negedge clk);
    arst_n      = 1'b1;
    instr_ready = 1'b0;
    reqs        = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (imem_req) reqs++;
      @(negedge clk);
    end
    #1;
    chk("stall_reqs", reqs, 32'd2);
    chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    chk("stall_instr", instr, mem_word(32'd0));
    chk("stall_pc4", instr_pc4, 32'd4);
    take("rel0", 32'd4);
    take("rel1", 32'd8);
    take("rel2", 32'd12);

    // branch and jump together: branch wins
    branch_en     = 1'b1;
    branch_target = 32'h0000_0100;
    jump_en       = 1'b1;
    jump_target   = 32'h0000_0200;
    #1;
    chk("bj_req_blk", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    branch_en = 1'b0;
    jump_en   = 1'b0;
    #1;
    chk("bj_req", {31'd0, imem_req}, 32'd1);
    chk("bj_addr", imem_addr, 32'h0000_0100);

    // branch while the 0x100 response is in flight
    @(negedge clk);
    branch_en     = 1'b1;
    branch_target = 32'h0000_0043;
    #1;
    chk("br_req_blk", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    branch_en = 1'b0;
    #1;
    chk("br_req", {31'd0, imem_req}, 32'd1);
    chk("br_addr", imem_addr, 32'h0000_0040);
    chk("br_flushed", {31'd0, instr_valid}, 32'd0);
    take("br_first", 32'h0000_0044);

    // PC wrap via jump to the last word
    jump_en     = 1'b1;
    jump_target = 32'hFFFF_FFFE;
    @(negedge clk);
    jump_en = 1'b0;
    #1;
    chk("wrap_req0", {31'd0, imem_req}, 32'd1);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    #1;
    chk("wrap_req1", {31'd0, imem_req}, 32'd1);
    chk("wrap_addr1", imem_addr, 32'h0000_0000);
    take("wrap_t0", 32'h0000_0000);
    take("wrap_t1", 32'h0000_0004);

`ifdef FETCH_PERF_CNT_EN
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      take("perf", 32'(k * 4));
    end
    #1;
    chk("perf_cnt", fetch_count, 32'd10);
    arst_n = 1'b0;
    #1;
    chk("perf_rst", fetch_count, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
